// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Default widths describe the baseline core configuration.
package wb_arbiter_pkg;

   localparam int WB_AW    = 5;
   localparam int WB_DW    = 32;
   localparam int WB_DEPTH = 2;

   localparam int unsigned REG_X0 = 0;

   typedef struct packed {
      logic             live;
      logic [WB_AW-1:0] rd;
      logic [WB_DW-1:0] data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_HEAD_FULL,
      SEL_ALU,
      SEL_HEAD
   } wb_sel_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of ALU/LSU result handshakes, register-file write port and bypass
// signals seen by the write-back arbiter.
interface wb_arbiter_if #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32
);
   logic                     alu_valid;
   logic                     alu_ready;
   logic [ADDRESS_WIDTH-1:0] alu_rd;
   logic [DATA_WIDTH-1:0]    alu_data;
   logic                     lsu_valid;
   logic                     lsu_ready;
   logic [ADDRESS_WIDTH-1:0] lsu_rd;
   logic [DATA_WIDTH-1:0]    lsu_data;
   logic                     we3;
   logic [ADDRESS_WIDTH-1:0] ad3;
   logic [DATA_WIDTH-1:0]    wd3;
   logic [ADDRESS_WIDTH-1:0] ad1;
   logic [ADDRESS_WIDTH-1:0] ad2;
   logic [DATA_WIDTH-1:0]    rd1_in;
   logic [DATA_WIDTH-1:0]    rd2_in;
   logic [DATA_WIDTH-1:0]    rd1_out;
   logic [DATA_WIDTH-1:0]    rd2_out;
   logic                     busy;

   modport master (
      output alu_valid, alu_rd, alu_data,
      output lsu_valid, lsu_rd, lsu_data,
      output ad1, ad2, rd1_in, rd2_in,
      input  alu_ready, lsu_ready, we3, ad3, wd3, rd1_out, rd2_out, busy
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  lsu_valid, lsu_rd, lsu_data,
      input  ad1, ad2, rd1_in, rd2_in,
      output alu_ready, lsu_ready, we3, ad3, wd3, rd1_out, rd2_out, busy
   );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// Small synchronous FIFO of write-back entries. A squash request clears the
// live bit of every stored entry whose destination matches.
module wb_fifo
   import wb_arbiter_pkg::*;
#(
   parameter type entry_t = wb_entry_t,
   parameter int  DEPTH   = WB_DEPTH,
   parameter int  RD_W    = WB_AW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  entry_t          push_entry,
   input  logic            pop,
   input  logic            squash_en,
   input  logic [RD_W-1:0] squash_rd,
   output entry_t          head,
   output logic            full,
   output logic            empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   entry_t        mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (squash_en && mem[i].rd == squash_rd) begin
               mem[i].live <= 1'b0;
            end
         end
         // A same-cycle push is younger than the squashing write, so it lands live.
         if (do_push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: picks one ALU or queued LSU result per cycle for the
// register-file write port and bypasses the registered write to the read ports.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int ADDRESS_WIDTH = WB_AW,
   parameter int DATA_WIDTH    = WB_DW,
   parameter int LSU_DEPTH     = WB_DEPTH
) (
   input logic         clk,
   input logic         rst,
   wb_arbiter_if.slave bus
);

   typedef struct packed {
      logic                     live;
      logic [ADDRESS_WIDTH-1:0] rd;
      logic [DATA_WIDTH-1:0]    data;
   } entry_t;

   localparam logic [ADDRESS_WIDTH-1:0] X0 = ADDRESS_WIDTH'(REG_X0);

   entry_t                   head;
   entry_t                   push_entry;
   logic                     full;
   logic                     empty;
   logic                     head_live;
   logic                     alu_fire;
   logic                     lsu_fire;
   logic                     push;
   logic                     pop;
   logic                     squash_en;
   wb_sel_e                  sel;
   logic                     wr_en;
   logic [ADDRESS_WIDTH-1:0] wr_rd;
   logic [DATA_WIDTH-1:0]    wr_data;

   assign head_live     = !empty && head.live;
   assign bus.lsu_ready = !rst && !full;
   assign bus.alu_ready = !rst && !(full && head_live);
   assign alu_fire      = bus.alu_valid && bus.alu_ready;
   assign lsu_fire      = bus.lsu_valid && bus.lsu_ready;
   assign push          = lsu_fire && (bus.lsu_rd != X0);
   assign squash_en     = alu_fire && (bus.alu_rd != X0);
   assign push_entry    = '{live: 1'b1, rd: bus.lsu_rd, data: bus.lsu_data};

   always_comb begin
      sel = SEL_NONE;
      if (full && head_live) begin
         sel = SEL_HEAD_FULL;
      end else if (bus.alu_valid) begin
         sel = SEL_ALU;
      end else if (head_live) begin
         sel = SEL_HEAD;
      end
   end

   // A dead head leaves in any cycle, alongside whatever else is written.
   assign pop = !empty && (!head.live || sel == SEL_HEAD_FULL || sel == SEL_HEAD);

   always_comb begin
      wr_en   = 1'b0;
      wr_rd   = head.rd;
      wr_data = head.data;
      case (sel)
         SEL_HEAD_FULL, SEL_HEAD: wr_en = 1'b1;
         SEL_ALU: begin
            wr_en   = bus.alu_rd != X0;
            wr_rd   = bus.alu_rd;
            wr_data = bus.alu_data;
         end
         default: wr_en = 1'b0;
      endcase
   end

   wb_fifo #(
      .entry_t (entry_t),
      .DEPTH   (LSU_DEPTH),
      .RD_W    (ADDRESS_WIDTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .squash_en  (squash_en),
      .squash_rd  (bus.alu_rd),
      .head       (head),
      .full       (full),
      .empty      (empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.we3 <= 1'b0;
         bus.ad3 <= '0;
         bus.wd3 <= '0;
      end else begin
         bus.we3 <= wr_en;
         if (wr_en) begin
            bus.ad3 <= wr_rd;
            bus.wd3 <= wr_data;
         end
      end
   end

   assign bus.busy = !empty;

   // The register file only absorbs we3/wd3 at the next edge, hence the bypass.
   assign bus.rd1_out = (bus.we3 && bus.ad3 != X0 && bus.ad3 == bus.ad1) ? bus.wd3 : bus.rd1_in;
   assign bus.rd2_out = (bus.we3 && bus.ad3 != X0 && bus.ad3 == bus.ad2) ? bus.wd3 : bus.rd2_in;

endmodule
